// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, DMA and BRAM-side signals around the data-memory arbiter.
// The arbiter takes the slave view; the surrounding core/DMA/BRAM (or a bench) take the master view.
interface dmem_arbiter_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 14
);
  // Core memory-stage port
  logic              core_req;
  logic [3:0]        core_we;
  logic [XLEN-1:0]   core_adr;
  logic [XLEN-1:0]   core_wdata;
  logic              core_stall;
  logic              core_rvalid;
  logic [XLEN-1:0]   core_rdata;

  // DMA / loader port
  logic              dma_req;
  logic [3:0]        dma_we;
  logic [XLEN-1:0]   dma_adr;
  logic [XLEN-1:0]   dma_wdata;
  logic              dma_last;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [XLEN-1:0]   dma_rdata;

  // Single-port BRAM
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  core_req, core_we, core_adr, core_wdata,
    input  dma_req, dma_we, dma_adr, dma_wdata, dma_last,
    input  mem_rdata,
    output core_stall, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_adr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_adr, core_wdata,
    output dma_req, dma_we, dma_adr, dma_wdata, dma_last,
    output mem_rdata,
    input  core_stall, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-BRAM arbiter between the core M-stage port and a DMA/loader engine.
// Core has default priority; a starvation counter and a capped burst lock guarantee DMA progress.
module dmem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_MAX    = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BeatW   = $clog2(BURST_MAX + 1);
  localparam logic [StarveW-1:0] StarveSat = StarveW'(STARVE_LIMIT);
  localparam logic [BeatW-1:0]   BeatMax   = BeatW'(BURST_MAX);
  localparam bit CanBurst = (BURST_MAX > 1);

  typedef enum logic [0:0] {StCore, StDma} state_e;

  state_e             state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [BeatW-1:0]   beat_q, beat_d, beat_inc;
  logic               core_rvalid_q, core_rvalid_d;
  logic               dma_rvalid_q, dma_rvalid_d;

  logic core_gnt, dma_gnt, dma_starved;

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    core_gnt    = 1'b0;
    dma_gnt     = 1'b0;
    dma_starved = bus.dma_req && (starve_q == StarveSat);
    if (rst) begin
      if ((state_q == StDma) && bus.dma_req) begin
        dma_gnt = 1'b1;
      end else begin
        core_gnt = bus.core_req && !dma_starved;
        dma_gnt  = bus.dma_req && !core_gnt;
      end
    end
  end

  // Burst lock and starvation bookkeeping
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    beat_inc = beat_q + BeatW'(1);

    unique case (state_q)
      StCore: begin
        if (dma_gnt && !bus.dma_last && CanBurst) begin
          state_d = StDma;
          beat_d  = BeatW'(1);
        end
      end
      StDma: begin
        if (dma_gnt) begin
          if (bus.dma_last || (beat_inc == BeatMax)) begin
            state_d = StCore;
            beat_d  = '0;
          end else begin
            beat_d = beat_inc;
          end
        end else begin
          // DMA dropped its request mid-lock: the burst is abandoned.
          state_d = StCore;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = StCore;
        beat_d  = '0;
      end
    endcase

    if (dma_gnt) begin
      starve_d = '0;
    end else if (bus.dma_req && (starve_q != StarveSat)) begin
      starve_d = starve_q + StarveW'(1);
    end

    core_rvalid_d = core_gnt && (bus.core_we == 4'b0000);
    dma_rvalid_d  = dma_gnt && (bus.dma_we == 4'b0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StCore;
      starve_q      <= '0;
      beat_q        <= '0;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      beat_q        <= beat_d;
      core_rvalid_q <= core_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
    end
  end

  // Memory mux: idle cycles park the address/data on the core inputs.
  assign bus.mem_en    = core_gnt || dma_gnt;
  assign bus.mem_we    = dma_gnt  ? bus.dma_we  :
                         core_gnt ? bus.core_we : 4'b0000;
  assign bus.mem_adr   = dma_gnt  ? bus.dma_adr[ADDR_W+1:2] : bus.core_adr[ADDR_W+1:2];
  assign bus.mem_wdata = dma_gnt  ? bus.dma_wdata : bus.core_wdata;

  assign bus.core_stall  = rst && bus.core_req && !core_gnt;
  assign bus.dma_gnt     = dma_gnt;
  assign bus.core_rvalid = rst && core_rvalid_q;
  assign bus.dma_rvalid  = rst && dma_rvalid_q;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.dma_rdata   = bus.mem_rdata;

  // Byte-offset and above-BRAM address bits are intentionally ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.core_adr[1:0], bus.core_adr[XLEN-1:ADDR_W+2],
                             bus.dma_adr[1:0],  bus.dma_adr[XLEN-1:ADDR_W+2]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, core-only, DMA burst, starvation, burst cap,
// abandoned burst and asynchronous reset in the middle of a burst.
module tb_dmem_arbiter;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned ADDR_W       = 14;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned BURST_MAX    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .XLEN        (XLEN),
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT),
    .BURST_MAX   (BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd_pat = 32'h1234_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic creq, input logic [3:0] cwe, input logic [31:0] cadr,
                       input logic dreq, input logic [3:0] dwe, input logic [31:0] dadr,
                       input logic dlast);
    @(negedge clk);
    bus.core_req   = creq;
    bus.core_we    = cwe;
    bus.core_adr   = cadr;
    bus.core_wdata = 32'hC000_0000 | cadr;
    bus.dma_req    = dreq;
    bus.dma_we     = dwe;
    bus.dma_adr    = dadr;
    bus.dma_wdata  = 32'hD000_0000 | dadr;
    bus.dma_last   = dlast;
    rd_pat         = rd_pat + 32'h0101_0101;
    bus.mem_rdata  = rd_pat;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic stall, input logic gnt,
                            input logic en, input logic crv, input logic drv);
    check_eq({tag, ".core_stall"},  32'(bus.core_stall),  32'(stall));
    check_eq({tag, ".dma_gnt"},     32'(bus.dma_gnt),     32'(gnt));
    check_eq({tag, ".mem_en"},      32'(bus.mem_en),      32'(en));
    check_eq({tag, ".core_rvalid"}, 32'(bus.core_rvalid), 32'(crv));
    check_eq({tag, ".dma_rvalid"},  32'(bus.dma_rvalid),  32'(drv));
    if (crv) check_eq({tag, ".core_rdata"}, bus.core_rdata, rd_pat);
    if (drv) check_eq({tag, ".dma_rdata"},  bus.dma_rdata,  rd_pat);
  endtask

  initial begin
    bus.core_req   = 1'b0;
    bus.core_we    = 4'h0;
    bus.core_adr   = 32'h0;
    bus.core_wdata = 32'h0;
    bus.dma_req    = 1'b0;
    bus.dma_we     = 4'h0;
    bus.dma_adr    = 32'h0;
    bus.dma_wdata  = 32'h0;
    bus.dma_last   = 1'b0;
    bus.mem_rdata  = 32'h0;
    #2 rst = 1'b0;

    // Reset holds every grant off even with both requesters active
    drive(1'b1, 4'h0, 32'h10, 1'b1, 4'hF, 32'h100, 1'b0);
    expect_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst.mem_we", 32'(bus.mem_we), 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Core-only reads of 0x10 -> word 4, data returns the next cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
      expect_out($sformatf("core%0d", i), 1'b0, 1'b0, 1'b1, i > 0, 1'b0);
      check_eq($sformatf("core%0d.mem_adr", i), 32'(bus.mem_adr), 32'h4);
      check_eq($sformatf("core%0d.mem_we", i),  32'(bus.mem_we),  32'h0);
    end
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    expect_out("core_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // DMA-only write burst 0x100..0x10C, last on the fourth beat
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h100 + 32'(4 * k), k == 3);
      expect_out($sformatf("dma%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq($sformatf("dma%0d.mem_we", k),    32'(bus.mem_we),  32'hF);
      check_eq($sformatf("dma%0d.mem_adr", k),   32'(bus.mem_adr), 32'h40 + 32'(k));
      check_eq($sformatf("dma%0d.mem_wdata", k), bus.mem_wdata,    32'hD000_0100 + 32'(4 * k));
    end

    // Contention: core wins 8 cycles, DMA forced in on the 9th and locks 4 beats
    for (int c = 1; c <= 8; c++) begin
      drive(1'b1, 4'h0, 32'h20, 1'b1, 4'h0, 32'h200, 1'b0);
      expect_out($sformatf("cont%0d", c), 1'b0, 1'b0, 1'b1, c > 1, 1'b0);
      check_eq($sformatf("cont%0d.mem_adr", c), 32'(bus.mem_adr), 32'h8);
    end
    drive(1'b1, 4'h0, 32'h20, 1'b1, 4'h0, 32'h200, 1'b0);
    expect_out("cont9", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("cont9.mem_adr", 32'(bus.mem_adr), 32'h80);
    for (int c = 10; c <= 12; c++) begin
      drive(1'b1, 4'h0, 32'h20, 1'b1, 4'h0, 32'h200, 1'b0);
      expect_out($sformatf("cap%0d", c), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    // Cap reached: core back in, starvation count restarted from zero
    for (int c = 13; c <= 20; c++) begin
      drive(1'b1, 4'h0, 32'h20, 1'b1, 4'h0, 32'h200, 1'b0);
      expect_out($sformatf("cont%0d", c), 1'b0, 1'b0, 1'b1, c > 13, c == 13);
    end
    drive(1'b1, 4'h0, 32'h20, 1'b1, 4'h0, 32'h200, 1'b1);
    expect_out("cont21", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'h0, 32'h20, 1'b1, 4'h0, 32'h200, 1'b0);
    expect_out("cont22", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Abandoned burst: two locked beats, then DMA drops and core is served at once
    drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h300, 1'b0);
    expect_out("ab1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h300, 1'b0);
    expect_out("ab2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'h0, 32'h30, 1'b0, 4'h0, 32'h0, 1'b0);
    expect_out("ab3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("ab3.mem_adr", 32'(bus.mem_adr), 32'hC);
    drive(1'b1, 4'h0, 32'h30, 1'b1, 4'h0, 32'h300, 1'b0);
    expect_out("ab4", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset during the second beat of a DMA read burst
    drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h400, 1'b0);
    expect_out("rb1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h400, 1'b0);
    expect_out("rb2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1 expect_out("rb_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 expect_out("rb_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    drive(1'b1, 4'h0, 32'h10, 1'b1, 4'h0, 32'h400, 1'b0);
    expect_out("rb_post", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rb_post.mem_adr", 32'(bus.mem_adr), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, 0 of 1 expected completions");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data BRAM between the core's memory-stage access port and a DMA/loader engine (UART program loader, memcpy engine).
- The core has default priority. A starvation counter guarantees DMA progress.
- A burst lock lets the DMA own the port for up to BURST_MAX consecutive beats.
- Denied core accesses raise core_stall, which feeds the hazard unit's stall logic. Read data returns one cycle later, tagged to the requester that issued the read.

Parameters:
XLEN, 32, data/address width
ADDR_W, 14, BRAM word-address width; mem_adr = adr[ADDR_W+1:2]
STARVE_LIMIT, 8, consecutive denied DMA cycles before DMA is forced ahead of core (>=1)
BURST_MAX, 4, maximum beats per DMA lock (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
core_req  in  1  core memory access valid (M stage)
core_we  in  4  core byte write enables; 0 = read
core_adr  in  XLEN  core byte address
core_wdata  in  XLEN  core write data
core_stall  out  1  core access not granted this cycle
core_rvalid  out  1  core read data valid
core_rdata  out  XLEN  core read data
dma_req  in  1  DMA access valid
dma_we  in  4  DMA byte write enables; 0 = read
dma_adr  in  XLEN  DMA byte address
dma_wdata  in  XLEN  DMA write data
dma_last  in  1  current DMA beat ends its burst
dma_gnt  out  1  DMA beat accepted this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  XLEN  DMA read data
mem_en  out  1  BRAM enable
mem_we  out  4  BRAM byte write enables
mem_adr  out  ADDR_W  BRAM word address
mem_wdata  out  XLEN  BRAM write data
mem_rdata  in  XLEN  BRAM read data, one-cycle latency

Behaviour:
- State: FSM {S_CORE, S_DMA}, starve_cnt (0..STARVE_LIMIT, saturating), beat_cnt (0..BURST_MAX), two rvalid tag flops.
- Reset (rst=0, asynchronous):
  - state=S_CORE, starve_cnt=0, beat_cnt=0, rvalid flops=0.
  - While rst=0, grants are forced 0: core_stall=0, dma_gnt=0, mem_en=0, mem_we=0, core_rvalid=dma_rvalid=0.
  - Reset mid-burst discards the lock. The first post-reset cycle arbitrates from S_CORE.
- Grant decision (combinational, same cycle):
  - S_CORE: core_gnt = core_req && !(dma_req && starve_cnt==STARVE_LIMIT); dma_gnt = dma_req && !core_gnt.
  - S_DMA: if dma_req, dma_gnt=1 and core_gnt=0. If !dma_req, arbitrate as in S_CORE.
- core_stall = core_req && !core_gnt. No stall when core_req=0.
- Memory mux:
  - The granted requester's we/adr/wdata drive mem_*; mem_en=1 on any grant.
  - No grant: mem_en=0, mem_we=0, mem_adr/mem_wdata hold the core inputs (don't care).
- Transitions:
  - S_CORE -> S_DMA when dma_gnt && !dma_last && BURST_MAX>1; beat_cnt<=1.
  - S_DMA, dma beat granted: beat_cnt<=beat_cnt+1. Return to S_CORE, beat_cnt<=0, when dma_last or beat_cnt+1==BURST_MAX.
  - S_DMA with dma_req=0: return to S_CORE, beat_cnt<=0 (the burst is abandoned).
- starve_cnt:
  - Increments, saturating, when dma_req && !dma_gnt.
  - Clears to 0 on dma_gnt.
  - Holds when dma_req=0.
- Read return:
  - core_rvalid <= core_gnt && core_we==0; dma_rvalid likewise for DMA.
  - core_rdata = dma_rdata = mem_rdata (passthrough); qualify with rvalid.
- Writes produce no rvalid.
- Back-to-back grants to different requesters are legal. The rvalid tag always follows the requester granted in the previous cycle.
- Misaligned addresses: low two bits are ignored. Byte lanes are the requester's responsibility.

Test Plan:
- Reset then core-only: core_req=1, core_we=0, core_adr=0x10 for 3 cycles -> core_stall=0, mem_adr=4, core_rvalid=1 one cycle after each grant; core_rdata=mem_rdata.
- DMA-only burst: dma_req=1, dma_we=4'hF, dma_adr=0x100..0x10C, dma_last on 4th beat -> dma_gnt=1 for 4 cycles, mem_we=4'hF, state returns to S_CORE.
- Contention/starvation: core_req and dma_req held high, STARVE_LIMIT=8 -> core granted 8 cycles with dma_gnt=0; 9th cycle dma_gnt=1, core_stall=1; then starve_cnt=0.
- Burst cap: starved DMA wins with dma_last=0 throughout, BURST_MAX=4, core_req=1 -> exactly 4 DMA beats with core_stall=1, then core granted.
- DMA abandons burst: after 2 locked beats dma_req drops with core_req=1 -> core granted that same cycle, beat_cnt=0.
- Async reset mid-burst: drop rst during 2nd DMA beat -> dma_gnt, mem_en and rvalids go 0 immediately; after release, core_req=1 is granted on the first cycle.
